// File: rtl/simon_serial_loader.sv
// simon_serial_loader
//   Upstream feeder for the bit-serial SIMON 128/128 core. Accepts a
//   plaintext/key pair over a start/ready handshake and drives the core's
//   data_in/data_rdy sequence: plaintext load, key load, one idle gap, then
//   RUN_CYCLES cycles of run code, followed by a one-cycle done pulse.
//
//   Optional feature macro: SIMON_LOADER_ABORT_EN (adds the abort input).
//
//   Ports:
//     clk        - single clock, rising edge
//     rst        - synchronous, active-high reset
//     abort      - (SIMON_LOADER_ABORT_EN only) return to IDLE, no done
//     start      - request, accepted only while ready=1
//     plaintext  - WIDTH-bit block, sampled on the accepting edge
//     key        - WIDTH-bit key, sampled on the accepting edge
//     ready      - high in IDLE only
//     data_in_o  - serial bit to core data_in
//     data_rdy_o - phase code: 0 idle/gap, 1 plaintext, 2 key, 3 run
//     done       - one-cycle pulse in the first IDLE cycle after RUN
module simon_serial_loader #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned RUN_CYCLES = 8704,
    parameter int unsigned CNT_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SIMON_LOADER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] key,
    output logic             ready,
    output logic             data_in_o,
    output logic [1:0]       data_rdy_o,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_PT  = 3'd1,
        LOAD_KEY = 3'd2,
        GAP      = 3'd3,
        RUN      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(RUN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pt_sr;
    logic [WIDTH-1:0] key_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pt_sr      <= '0;
            key_sr     <= '0;
            ready      <= 1'b1;
            data_in_o  <= 1'b0;
            data_rdy_o <= 2'd0;
            done       <= 1'b0;
        end
`ifdef SIMON_LOADER_ABORT_EN
        else if (abort && state != IDLE) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b1;
            data_in_o  <= 1'b0;
            data_rdy_o <= 2'd0;
            done       <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    // done is only ever high in the first IDLE cycle
                    done <= 1'b0;
                    if (start) begin
                        state      <= LOAD_PT;
                        pt_sr      <= plaintext;
                        key_sr     <= key;
                        cnt        <= '0;
                        ready      <= 1'b0;
                        data_rdy_o <= 2'd1;
                        data_in_o  <= plaintext[0];
                    end
                end

                LOAD_PT: begin
                    if (cnt == LAST_BIT) begin
                        state      <= LOAD_KEY;
                        cnt        <= '0;
                        data_rdy_o <= 2'd2;
                        data_in_o  <= key_sr[0];
                    end else begin
                        // Output is registered, so present the next bit (sr[1])
                        // while shifting.
                        pt_sr     <= pt_sr >> 1;
                        data_in_o <= pt_sr[1];
                        cnt       <= cnt + 1'b1;
                    end
                end

                LOAD_KEY: begin
                    if (cnt == LAST_BIT) begin
                        state      <= GAP;
                        cnt        <= '0;
                        data_rdy_o <= 2'd0;
                        data_in_o  <= 1'b0;
                    end else begin
                        key_sr    <= key_sr >> 1;
                        data_in_o <= key_sr[1];
                        cnt       <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    state      <= RUN;
                    cnt        <= '0;
                    data_rdy_o <= 2'd3;
                    data_in_o  <= 1'b0;
                end

                RUN: begin
                    if (cnt == LAST_RUN) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        done       <= 1'b1;
                        ready      <= 1'b1;
                        data_rdy_o <= 2'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    ready      <= 1'b1;
                    data_in_o  <= 1'b0;
                    data_rdy_o <= 2'd0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
